// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch queue of {pc, instr} entries with flush
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               wdata,
    output fetch_entry_t               rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  head;
    logic [AW-1:0]  tail;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[head];

    // Pointers are exactly AW bits wide, so wrap modulo DEPTH is free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + 1'b1;
            if (do_pop)  head <= head + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[tail] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC register, prefetch control and redirect handling
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc
);

    logic [31:0]             fetch_pc;
    logic                    push;
    logic                    pop;
    logic                    full;
    logic                    empty;
    logic [$clog2(DEPTH):0]  count;
    fetch_entry_t            wdata;
    fetch_entry_t            rdata;

    assign imem_addr = fetch_pc;
    assign pop       = dec_valid && dec_ready;
    assign push      = fetch_en && !redirect_valid && (!full || pop);
    assign wdata     = '{pc: fetch_pc, instr: imem_rdata};

    // Outputs come straight from the queue head; empty masks to NOP / 0.
    assign dec_valid = !empty;
    assign dec_instr = empty ? INSTR_NOP : rdata.instr;
    assign dec_pc    = empty ? 32'h0 : rdata.pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fetch_pc <= RESET_PC;
        else if (redirect_valid)
            fetch_pc <= {redirect_pc[31:2], 2'b00};
        else if (push)
            fetch_pc <= fetch_pc + 32'd4;
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (wdata),
        .rdata (rdata),
        .count (count),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized and directed checks of fetch_unit against a queue model
module tb_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;

    logic        w_en = 1'b0;
    logic [31:0] w_addr;
    logic [31:0] w_rdata;
    logic        w_valid;
    logic [31:0] w_instr;
    logic [31:0] w_pc;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_pc;
    logic [63:0] m_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h1000_0000 + {2'b00, addr[31:2]};
    endfunction

    assign imem_rdata = mem_word(imem_addr);
    assign w_rdata    = mem_word(w_addr);

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (w_en),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .imem_addr      (w_addr),
        .imem_rdata     (w_rdata),
        .dec_valid      (w_valid),
        .dec_ready      (1'b1),
        .dec_instr      (w_instr),
        .dec_pc         (w_pc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [63:0] head;
        check("imem_addr", imem_addr, m_pc);
        check("dec_valid", {31'b0, dec_valid}, {31'b0, m_q.size() > 0});
        if (m_q.size() > 0) begin
            head = m_q[0];
            check("dec_pc", dec_pc, head[63:32]);
            check("dec_instr", dec_instr, head[31:0]);
        end else begin
            check("dec_pc_empty", dec_pc, 32'h0);
            check("dec_instr_empty", dec_instr, 32'h0000_0013);
        end
    endtask

    // Called at a falling edge: check, drive, advance model, wait one cycle.
    task automatic cycle(input logic en, input logic rdy, input logic rv, input logic [31:0] rpc);
        bit pop;
        bit push;
        compare_model();
        fetch_en       = en;
        dec_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        pop  = (m_q.size() > 0) && rdy;
        push = en && !rv && ((m_q.size() < DEPTH) || pop);
        if (pop) void'(m_q.pop_front());
        if (rv) begin
            m_q.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else if (push) begin
            m_q.push_back({m_pc, mem_word(m_pc)});
            m_pc = m_pc + 32'd4;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        dec_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        w_en           = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_pc  = 32'h0;
        m_q.delete();
    endtask

    logic [31:0] wrap_exp [4];

    initial begin
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;
        wrap_exp[3] = 32'h0000_0004;

        do_reset();
        check("rst_valid", {31'b0, dec_valid}, 32'h0);
        check("rst_instr", dec_instr, 32'h0000_0013);
        check("rst_pc", dec_pc, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);

        // Streaming from reset, one instruction per cycle
        cycle(1, 1, 0, 0);
        check("first_valid", {31'b0, dec_valid}, 32'h1);
        check("first_pc", dec_pc, 32'h0);
        check("first_instr", dec_instr, 32'h1000_0000);
        for (int i = 1; i < 6; i++) begin
            cycle(1, 1, 0, 0);
            check("stream_pc", dec_pc, 32'(4 * i));
        end

        // Backpressure fills the queue, then drains without a gap
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0);
        check("bp_addr", imem_addr, 32'd16);
        check("bp_pc", dec_pc, 32'h0);
        for (int i = 0; i < 5; i++) begin
            check("drain_pc", dec_pc, 32'(4 * i));
            cycle(1, 1, 0, 0);
        end

        // Toggled ready keeps the queue around full
        for (int i = 0; i < 50; i++) cycle(1, 1'(i & 1), 0, 0);

        // Redirect with 3 entries queued
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
        check("pre_redir_pc", dec_pc, 32'h0);
        cycle(1, 1, 1, 32'h0000_0102);
        check("redir_valid", {31'b0, dec_valid}, 32'h0);
        check("redir_addr", imem_addr, 32'h0000_0100);
        cycle(1, 1, 0, 0);
        check("redir_tgt_valid", {31'b0, dec_valid}, 32'h1);
        check("redir_tgt_pc", dec_pc, 32'h0000_0100);
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0);

        // Back-to-back redirects, and one with fetch disabled
        cycle(1, 0, 1, 32'h0000_0400);
        cycle(1, 0, 1, 32'h0000_0800);
        cycle(0, 1, 1, 32'h0000_0C01);
        check("redir_noen_addr", imem_addr, 32'h0000_0C00);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);

        // PC wrap on the second instance
        do_reset();
        w_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 0, 0);
            check("wrap_pc", w_pc, wrap_exp[k]);
        end
        w_en = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            cycle(($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 4) < 3),
                  ($urandom_range(0, 19) == 0),
                  $urandom());
        end

        // Async reset with 2 entries queued
        do_reset();
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        check("pre_arst_valid", {31'b0, dec_valid}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", {31'b0, dec_valid}, 32'h0);
        check("arst_addr", imem_addr, 32'h0);
        check("arst_pc", dec_pc, 32'h0);
        m_pc = 32'h0;
        m_q.delete();
        fetch_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 1, 0, 0);
        check("restart_pc", dec_pc, 32'h0);
        for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the instruction memory.
- Holds the program counter (PC) and drives the word address to the instruction memory.
- Captures the combinationally returned instruction, paired with its PC, into a small prefetch queue.
- Presents queue entries to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing the queue and restarting at the target.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
DEPTH, 4, prefetch queue entries; power of two, minimum 2.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
fetch_en  input  1  high allows fetching; low holds PC and stops pushes
redirect_valid  input  1  one-cycle pulse requesting a PC change
redirect_pc  input  32  redirect target; bits [1:0] forced to 0 on load
imem_addr  output  32  byte address to instruction memory, equal to fetch_pc register
imem_rdata  input  32  instruction returned combinationally for imem_addr in the same cycle
dec_valid  output  1  queue head holds a valid instruction
dec_ready  input  1  decode accepts the head this cycle
dec_instr  output  32  head instruction; 32'h0000_0013 (NOP) when empty
dec_pc  output  32  PC of head instruction; 32'h0 when empty

Behaviour:
Reset (async assert, synchronous release on clk):
- fetch_pc = RESET_PC; queue empty; count = 0.
- dec_valid = 0, dec_instr = NOP, dec_pc = 0, imem_addr = RESET_PC.

Signal definitions:
- imem_addr = fetch_pc (pure register output, no combinational path from inputs).
- pop = dec_valid && dec_ready.
- push = fetch_en && !redirect_valid && (count < DEPTH || pop).

Push:
- Writes {fetch_pc, imem_rdata} at the tail.
- fetch_pc <= fetch_pc + 4, with modulo-2^32 wrap (32'hFFFF_FFFC -> 32'h0).

Output and latency:
- dec_* is driven from registered head storage only; there is no same-cycle bypass from imem_rdata.
- First instruction is visible on dec_valid in the cycle after the first push edge.
- Steady state sustains one instruction per cycle with dec_ready held high.

Queue boundaries:
- Full with no pop: push suppressed; fetch_pc holds; count stays DEPTH.
- Full with pop: push and pop both occur; count unchanged.
- Empty: pop impossible because dec_valid = 0.
- Head and tail pointers wrap modulo DEPTH.
- Count width is clog2(DEPTH)+1.

Redirect (highest priority):
- At the clock edge: queue flushed (count = 0, pointers reset); fetch_pc <= {redirect_pc[31:2], 2'b00}.
- No push in the redirect cycle.
- If dec_ready is high in the redirect cycle, decode consumes the head as a normal transfer; the flush discards all remaining entries.
- dec_valid = 0 in the cycle after a redirect.
- First target instruction is visible 2 cycles after the redirect edge.
- Back-to-back redirects: the last one wins.
- A redirect with fetch_en = 0 still flushes and loads the PC.

fetch_en low:
- No push; fetch_pc holds; draining to decode continues normally.

Reset mid-operation:
- Immediate return to reset state regardless of queue contents or redirect.

Decomposition:
Shared package fetch_pkg contains:
- INSTR_NOP = 32'h0000_0013.
- XLEN = 32.
- typedef fetch_entry_t, a packed struct of pc[31:0] and instr[31:0].

One natural sub-module, fetch_fifo:
- Parameterised DEPTH, storing fetch_entry_t.
- Ports: push, pop, flush, wdata, rdata, count, full, empty.
- Async active-low reset.

fetch_unit owns the PC register and the push/redirect control.

Test Plan:
- Reset release, RESET_PC = 0, memory word i = 32'h1000_0000 + i, dec_ready = 1:
  - Cycle 1: dec_pc = 0, dec_instr = 32'h1000_0000.
  - One instruction per cycle thereafter: dec_pc = 4, 8, 12…
- Backpressure, dec_ready = 0 for 10 cycles:
  - imem_addr stops at 16 (DEPTH = 4); dec_pc held at 0.
  - On release, dec_pc = 0, 4, 8, 12, 16 on consecutive cycles with no gap.
- Full queue with simultaneous pop, dec_ready toggled 1/0:
  - Count never exceeds 4; no PC skipped or duplicated over 50 cycles.
- Redirect to 32'h0000_0102 while the queue holds 3 entries:
  - Next cycle dec_valid = 0; imem_addr = 32'h0000_0100.
  - Two cycles after the redirect edge, dec_pc = 32'h100.
  - No stale PC is ever presented.
- PC wrap, RESET_PC = 32'hFFFF_FFF8:
  - dec_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Async reset asserted mid-stream with 2 entries queued:
  - dec_valid falls to 0 without a clock edge; imem_addr = RESET_PC.
  - After release, fetch restarts from RESET_PC.
